// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: multi-port operand forwarding from prioritised sources,
// multiply/divide countdown interlock and saturating stall-cycle counter.
module forward_hazard_unit #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int NUM_READ = 2,
   parameter int NUM_SRC  = 3,
   parameter int MD_CW    = 6,
   parameter int CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_READ-1:0]          rd_en,
   input  logic [NUM_READ*REG_AW-1:0]   rd_addr,
   input  logic [NUM_READ*DATA_W-1:0]   rd_orig,
   output logic [NUM_READ*DATA_W-1:0]   rd_value,
   input  logic [NUM_SRC-1:0]           src_valid,
   input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
   input  logic [NUM_SRC*DATA_W-1:0]    src_value,
   input  logic                         md_start,
   input  logic [MD_CW-1:0]             md_cycles,
   input  logic                         md_use,
   input  logic                         flush,
   input  logic                         stat_clr,
   output logic                         stall,
   output logic                         md_busy,
   output logic [MD_CW-1:0]             md_remaining,
   output logic [CNT_W-1:0]             stall_count
);
   logic [NUM_READ-1:0] hazard;
   logic                md_hazard;
   genvar i;
   generate
      for (i = 0; i < NUM_READ; i++) begin : g_port
         logic [REG_AW-1:0] a;
         logic [DATA_W-1:0] v;
         logic              h;
         assign a = rd_addr[i*REG_AW +: REG_AW];
         // scan youngest-last so the lowest-index match overrides older ones
         always_comb begin
            v = rd_orig[i*DATA_W +: DATA_W];
            h = 1'b0;
            for (int j = NUM_SRC-1; j >= 0; j--)
               if (src_addr[j*REG_AW +: REG_AW] == a) begin
                  v = src_value[j*DATA_W +: DATA_W];
                  h = ~src_valid[j];
               end
            if (a == '0) begin
               v = '0;
               h = 1'b0;
            end
         end
         assign rd_value[i*DATA_W +: DATA_W] = v;
         assign hazard[i] = h & rd_en[i];
      end
   endgenerate
   assign md_busy   = |md_remaining;
   assign md_hazard = md_use & (md_busy | (md_start & |md_cycles));
   assign stall     = ~flush & (|hazard | md_hazard);
   always_ff @(posedge clk or negedge reset)
      if (!reset) md_remaining <= '0;
      else if (md_start) md_remaining <= md_cycles;
      else if (md_busy) md_remaining <= md_remaining - 1'b1;
   always_ff @(posedge clk or negedge reset)
      if (!reset) stall_count <= '0;
      else if (stat_clr) stall_count <= '0;
      else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed checks of forwarding priority, interlocks and
// stall counter, plus a short random forwarding sweep against a reference model.
module tb_forward_hazard_unit;
   localparam int DW = 32, AW = 5, NR = 2, NS = 3, MW = 6, CW = 4;
   logic clk = 1'b0, reset = 1'b0;
   logic [NR-1:0] rd_en = '0;
   logic [NR*AW-1:0] rd_addr = '0;
   logic [NR*DW-1:0] rd_orig = '0, rd_value;
   logic [NS-1:0] src_valid = '0;
   logic [NS*AW-1:0] src_addr = '0;
   logic [NS*DW-1:0] src_value = '0;
   logic md_start = 1'b0, md_use = 1'b0, flush = 1'b0, stat_clr = 1'b0;
   logic [MW-1:0] md_cycles = '0, md_remaining;
   logic stall, md_busy;
   logic [CW-1:0] stall_count;
   int n_chk = 0, n_fail = 0;

   forward_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_READ(NR), .NUM_SRC(NS),
                         .MD_CW(MW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_orig(rd_orig),
      .rd_value(rd_value), .src_valid(src_valid), .src_addr(src_addr),
      .src_value(src_value), .md_start(md_start), .md_cycles(md_cycles),
      .md_use(md_use), .flush(flush), .stat_clr(stat_clr), .stall(stall),
      .md_busy(md_busy), .md_remaining(md_remaining), .stall_count(stall_count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] ev;
      logic eh, found, any_h;
      logic [AW-1:0] a, sa;
      #2;
      chk("reset_md_remaining", md_remaining, 0);
      chk("reset_md_busy", md_busy, 0);
      chk("reset_stall_count", stall_count, 0);
      reset = 1'b1;
      // priority and zero register
      rd_addr = {5'd0, 5'd5};
      src_addr = {5'd5, 5'd5, 5'd5};
      src_value = {32'hC, 32'hB, 32'hA};
      src_valid = 3'b111;
      rd_orig = {32'h22, 32'h11};
      rd_en = 2'b11;
      #1;
      chk("prio_value", rd_value, {32'h0, 32'hA});
      chk("prio_stall", stall, 0);
      src_addr[4:0] = 5'd7;
      #1;
      chk("prio_second", rd_value, {32'h0, 32'hB});
      rd_addr = {5'd3, 5'd3};
      #1;
      chk("no_match_orig", rd_value, {32'h22, 32'h11});
      // not-ready source blocks valid lower-priority one
      src_addr = {5'd0, 5'd9, 5'd9};
      src_valid = 3'b110;
      rd_addr = {5'd9, 5'd0};
      rd_en = 2'b10;
      #1;
      chk("notready_stall", stall, 1);
      rd_en = 2'b00;
      #1;
      chk("notready_unused", stall, 0);
      rd_en = 2'b10;
      flush = 1'b1;
      #1;
      chk("notready_flush", stall, 0);
      flush = 1'b0;
      rd_en = 2'b00;
      // md interlock
      @(negedge clk);
      md_use = 1'b1;
      md_start = 1'b1;
      md_cycles = 6'd4;
      #1;
      chk("md_issue_stall", stall, 1);
      tick();
      md_start = 1'b0;
      chk("md_busy_4", md_busy, 1);
      for (int k = 4; k >= 1; k--) begin
         chk("md_remaining", md_remaining, k);
         chk("md_stall", stall, 1);
         if (k > 1) tick();
      end
      tick();
      chk("md_done_remaining", md_remaining, 0);
      chk("md_done_stall", stall, 0);
      md_start = 1'b1;
      md_cycles = 6'd0;
      #1;
      chk("md_zero_stall", stall, 0);
      tick();
      md_start = 1'b0;
      chk("md_zero_busy", md_busy, 0);
      // flush masks stall but the op still runs
      flush = 1'b1;
      md_start = 1'b1;
      md_cycles = 6'd2;
      #1;
      chk("flush_md_stall", stall, 0);
      tick();
      md_start = 1'b0;
      chk("flush_md_remaining", md_remaining, 2);
      flush = 1'b0;
      #1;
      chk("unflush_md_stall", stall, 1);
      tick();
      tick();
      md_use = 1'b0;
      // reload and async reset
      md_start = 1'b1;
      md_cycles = 6'd10;
      tick();
      md_start = 1'b0;
      tick();
      tick();
      chk("reload_pre", md_remaining, 8);
      md_start = 1'b1;
      md_cycles = 6'd3;
      tick();
      chk("reload_value", md_remaining, 3);
      md_cycles = 6'd5;
      tick();
      md_start = 1'b0;
      chk("pre_reset_value", md_remaining, 5);
      reset = 1'b0;
      #1;
      chk("async_reset_remaining", md_remaining, 0);
      chk("async_reset_busy", md_busy, 0);
      reset = 1'b1;
      // stall counter saturation and clear
      rd_en = 2'b10;
      stat_clr = 1'b1;
      tick();
      chk("clr_count", stall_count, 0);
      stat_clr = 1'b0;
      tick();
      chk("count_first", stall_count, 1);
      for (int k = 0; k < 20; k++) tick();
      chk("count_saturate", stall_count, 15);
      stat_clr = 1'b1;
      tick();
      chk("clr_priority", stall_count, 0);
      stat_clr = 1'b0;
      tick();
      chk("count_after_clr", stall_count, 1);
      // random forwarding sweep
      for (int it = 0; it < 300; it++) begin
         rd_en = NR'($urandom);
         flush = 1'($urandom_range(0, 3) == 0);
         src_valid = NS'($urandom);
         for (int p = 0; p < NR; p++) begin
            rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3));
            rd_orig[p*DW +: DW] = $urandom;
         end
         for (int s = 0; s < NS; s++) begin
            src_addr[s*AW +: AW] = AW'($urandom_range(0, 3));
            src_value[s*DW +: DW] = $urandom;
         end
         #1;
         any_h = 1'b0;
         for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            ev = rd_orig[p*DW +: DW];
            eh = 1'b0;
            found = 1'b0;
            if (a == 0) ev = '0;
            else
               for (int s = 0; s < NS; s++) begin
                  sa = src_addr[s*AW +: AW];
                  if (!found && sa == a) begin
                     found = 1'b1;
                     ev = src_value[s*DW +: DW];
                     eh = !src_valid[s];
                  end
               end
            if (!eh) chk("rand_value", rd_value[p*DW +: DW], ev);
            any_h |= eh & rd_en[p];
         end
         chk("rand_stall", stall, !flush && any_h);
         #4;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
